// File: rtl/isa_mem_target_if.sv
// ISA memory-cycle address and strobe signals plus the target's handshake outputs.
// The SD data bus stays a plain inout port on the target.
interface isa_mem_target_if;
  logic [6:0]  isa_la_addr;
  logic [15:0] isa_addr;
  logic        bale;
  logic        mem_r;
  logic        mem_w;
  logic        io_chrdy;
  logic        data_oe;

  modport master (
    output isa_la_addr, isa_addr, bale, mem_r, mem_w,
    input  io_chrdy, data_oe
  );

  modport slave (
    input  isa_la_addr, isa_addr, bale, mem_r, mem_w,
    output io_chrdy, data_oe
  );
endinterface

// File: rtl/isa_mem_target.sv
// ISA 16-bit memory target: a 128-byte window holding an ID word, an access counter
// and 62 read/write words, answering with a fixed IOCHRDY wait on every hit access.
module isa_mem_target #(
  parameter logic [22:0] BASE_ADDR   = 23'h0D0000,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [15:0] ID_WORD     = 16'hA55A
) (
  input  logic            clk,
  input  logic            rst,
  isa_mem_target_if.slave bus,
  inout  wire  [15:0]     isa_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DRIVE = 3'd3,
    WR_WAIT  = 3'd4,
    WR_HOLD  = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [1:0]  bale_sync_r;
  logic [1:0]  mem_r_sync_r;
  logic [1:0]  mem_w_sync_r;
  logic        bale_prev_r;
  logic        mem_r_prev_r;
  logic        mem_w_prev_r;
  logic [3:0]  wait_cnt_r;
  logic [5:0]  word_idx_r;
  logic [15:0] access_cnt_r;
  logic [15:0] regs_r [0:63];
  logic        io_chrdy_r;
  logic        data_oe_r;
  logic [15:0] data_out_r;

  logic [22:0] addr_s;
  logic        hit_s;
  logic        bale_fall_s;
  logic        mem_r_fall_s;
  logic        mem_r_rise_s;
  logic        mem_w_fall_s;
  logic        mem_w_rise_s;
  logic        both_low_s;
  logic [15:0] rd_word_s;
  logic        unused_addr_s;

  // Two-flop synchronizers and edge-history flops for the ISA strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bale_sync_r  <= 2'b00;
      mem_r_sync_r <= 2'b11;
      mem_w_sync_r <= 2'b11;
      bale_prev_r  <= 1'b0;
      mem_r_prev_r <= 1'b1;
      mem_w_prev_r <= 1'b1;
    end else begin
      bale_sync_r  <= {bale_sync_r[0], bus.bale};
      mem_r_sync_r <= {mem_r_sync_r[0], bus.mem_r};
      mem_w_sync_r <= {mem_w_sync_r[0], bus.mem_w};
      bale_prev_r  <= bale_sync_r[1];
      mem_r_prev_r <= mem_r_sync_r[1];
      mem_w_prev_r <= mem_w_sync_r[1];
    end
  end

  // Address decode and edge detection on the synchronized strobes
  always_comb begin
    addr_s        = {bus.isa_la_addr, bus.isa_addr};
    hit_s         = (addr_s[22:7] == BASE_ADDR[22:7]);
    unused_addr_s = addr_s[0];
    bale_fall_s   = bale_prev_r & ~bale_sync_r[1];
    mem_r_fall_s  = mem_r_prev_r & ~mem_r_sync_r[1];
    mem_r_rise_s  = ~mem_r_prev_r & mem_r_sync_r[1];
    mem_w_fall_s  = mem_w_prev_r & ~mem_w_sync_r[1];
    mem_w_rise_s  = ~mem_w_prev_r & mem_w_sync_r[1];
    both_low_s    = ~mem_r_sync_r[1] & ~mem_w_sync_r[1];
  end

  // Read mux: word 0 is the ID constant, word 1 the live access counter
  always_comb begin
    if (word_idx_r == 6'd0) begin
      rd_word_s = ID_WORD;
    end else if (word_idx_r == 6'd1) begin
      rd_word_s = access_cnt_r;
    end else begin
      rd_word_s = regs_r[word_idx_r];
    end
  end

  // Access FSM with registered bus outputs, register file and access counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      io_chrdy_r   <= 1'b1;
      data_oe_r    <= 1'b0;
      data_out_r   <= 16'h0000;
      wait_cnt_r   <= 4'd0;
      word_idx_r   <= 6'd0;
      access_cnt_r <= 16'h0000;
      for (int i = 0; i < 64; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (bale_fall_s) begin
            word_idx_r <= addr_s[6:1];
            if (hit_s) begin
              state_r <= ARMED;
            end
          end
        end
        ARMED: begin
          // Conflicting strobes abort silently; a fresh address phase re-arms or drops
          if (both_low_s) begin
            state_r <= IDLE;
          end else if (bale_fall_s) begin
            word_idx_r <= addr_s[6:1];
            state_r    <= hit_s ? ARMED : IDLE;
          end else if (mem_r_fall_s) begin
            state_r    <= RD_WAIT;
            io_chrdy_r <= 1'b0;
            wait_cnt_r <= WAIT_LOAD;
          end else if (mem_w_fall_s) begin
            state_r    <= WR_WAIT;
            io_chrdy_r <= 1'b0;
            wait_cnt_r <= WAIT_LOAD;
          end
        end
        RD_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r    <= RD_DRIVE;
            io_chrdy_r <= 1'b1;
            data_oe_r  <= 1'b1;
            data_out_r <= rd_word_s;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        RD_DRIVE: begin
          if (mem_r_rise_s) begin
            state_r      <= IDLE;
            data_oe_r    <= 1'b0;
            access_cnt_r <= access_cnt_r + 16'd1;
          end
        end
        WR_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r    <= WR_HOLD;
            io_chrdy_r <= 1'b1;
            if (word_idx_r >= 6'd2) begin
              regs_r[word_idx_r] <= isa_data;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        WR_HOLD: begin
          if (mem_w_rise_s) begin
            state_r      <= IDLE;
            access_cnt_r <= access_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          io_chrdy_r <= 1'b1;
          data_oe_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_chrdy = io_chrdy_r;
  assign bus.data_oe  = data_oe_r;
  assign isa_data     = data_oe_r ? data_out_r : 16'hzzzz;

endmodule

// File: doc/isa_mem_target.md
ISA_MEM_TARGET -- requirements
Module: isa_mem_target

Interface
REQ-001 Parameter BASE_ADDR, 23'h0D0000, 128-byte window base; bits [6:0] SHALL be zero.
REQ-002 Parameter WAIT_CYCLES, 4, clk cycles io_chrdy is held low per access (range 1..15).
REQ-003 Parameter ID_WORD, 16'hA55A, read-only value of word 0.
REQ-004 clk  in  1  single clock, 50 MHz; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 isa_la_addr  in  7  ISA LA[23:17], mapped to address bits [22:16].
REQ-007 isa_addr  in  16  ISA SA[15:0], mapped to address bits [15:0].
REQ-008 bale  in  1  address latch enable, active high.
REQ-009 mem_r  in  1  ISA MEMR#, active low.
REQ-010 mem_w  in  1  ISA MEMW#, active low.
REQ-011 isa_data  inout  16  ISA SD[15:0]; driven only while data_oe=1, else high-Z.
REQ-012 io_chrdy  out  1  ISA IOCHRDY; 0 = insert wait, 1 = ready.
REQ-013 data_oe  out  1  transceiver enable/direction; 1 = target drives isa_data.

Function
REQ-014 bale, mem_r, mem_w SHALL pass through a 2-flop synchronizer before any use; edges are detected on synchronized values.
REQ-015 Address {isa_la_addr, isa_addr} SHALL be latched on the cycle a synchronized bale falling edge is detected.
REQ-016 Hit SHALL be latched_addr[22:7] == BASE_ADDR[22:7]; word index = latched_addr[6:1]; bit 0 ignored (16-bit only).
REQ-017 Register file: 64 x 16; word 0 = ID_WORD (RO), word 1 = access counter (RO), words 2..63 RW, reset 0.
REQ-018 Access counter SHALL increment by 1 on each completed hit access (read or write), wrapping 16'hFFFF -> 0.
REQ-019 FSM states: IDLE, ARMED, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD.
REQ-020 IDLE -> ARMED on bale fall with hit; miss stays IDLE and never touches io_chrdy or isa_data.
REQ-021 ARMED: new bale fall re-latches (hit stays ARMED, miss -> IDLE); mem_r fall -> RD_WAIT; mem_w fall -> WR_WAIT.
REQ-022 mem_r and mem_w both low in same cycle in ARMED SHALL go IDLE with no response and no counter change.
REQ-023 RD_WAIT: io_chrdy=0 for exactly WAIT_CYCLES cycles, then -> RD_DRIVE.
REQ-024 RD_DRIVE: io_chrdy=1, data_oe=1, isa_data = selected word, registered; on synchronized mem_r rise -> IDLE, data_oe=0 next cycle, counter increments.
REQ-025 WR_WAIT: io_chrdy=0 for exactly WAIT_CYCLES cycles; on the last wait cycle isa_data SHALL be registered and written to the word (RO words ignored) -> WR_HOLD.
REQ-026 WR_HOLD: io_chrdy=1; on synchronized mem_w rise -> IDLE, counter increments.
REQ-027 io_chrdy SHALL be 1 and data_oe 0 in IDLE, ARMED, WR_WAIT, WR_HOLD (data_oe) and all non-wait states (io_chrdy).
REQ-028 Read of word 1 SHALL return the counter value before that read's increment.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, io_chrdy=1, data_oe=0, isa_data high-Z, counter 0, words 2..63 = 0, synchronizers = inactive (bale 0, mem_r 1, mem_w 1).
REQ-030 Reset asserted mid-access SHALL abort without writing and release the bus in the same cycle.

Verification
REQ-031 bale pulse with addr 23'h0D0004, mem_w low, data 16'h1234 -> io_chrdy low 4 cycles, word 2 = 16'h1234, counter = 1.
REQ-032 Then read 23'h0D0004 -> io_chrdy low 4 cycles, isa_data = 16'h1234 while mem_r low, data_oe 0 one cycle after mem_r rise, counter = 2.
REQ-033 Read 23'h0D0000 -> 16'hA55A; write 16'hFFFF to 23'h0D0002 then read -> counter value, not 16'hFFFF.
REQ-034 Access to 23'h0E0004 -> io_chrdy stays 1, data_oe stays 0, counter unchanged.
REQ-035 mem_r and mem_w low simultaneously after hit -> no wait, no drive, counter unchanged; rst pulse during RD_WAIT -> io_chrdy=1, data_oe=0 immediately.
REQ-036 Preload counter to 16'hFFFF via 65535 accesses (or force), one more access -> counter = 16'h0000.
